imu_seq: RTL and testbench
==========================

# imu_seq

Command sequencer upstream of the 16-bit SPI master. After reset it waits a power-up delay, issues a fixed set of register-write commands to the inertial sensor, then on every data-ready interrupt issues two register reads (yaw-rate low/high byte) and presents the assembled 16-bit yaw rate with a one-cycle valid strobe. It drives the master's `wrt`/`cmd` and consumes its `done`/`rd_data`.

## Interface
- `INIT_DLY_W`, 16: width of the power-up delay counter; delay is 2^INIT_DLY_W clocks.
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset. One clock, `clk`; reset is synchronous and active-low.
- `INT` input 1: sensor data-ready, active high, level.
- `done` input 1: SPI master transaction complete (level, cleared by the master after `wrt`).
- `rd_data` input 16: SPI master read data; byte of interest is `rd_data[7:0]`.
- `wrt` output 1: one-cycle pulse starting an SPI transaction.
- `cmd` output 16: command word to SPI master; stable from `wrt` until `done` rises.
- `yaw_rt` output 16: last assembled yaw rate, `{high_byte, low_byte}`.
- `vld` output 1: one-cycle pulse when `yaw_rt` updates.
- `init_done` output 1: high once all init writes completed; stays high until reset.

## Operation
- States: `PWR_WAIT`, `INIT0`, `INIT1`, `INIT2`, `INIT3`, `WAIT_INT`, `RD_L`, `RD_H`, `UPDATE`.
- `PWR_WAIT`: delay counter increments each clock; on all-ones go to `INIT0` and pulse `wrt` with `cmd=0x0D02`.
- `INITn` commands, in order: `0x0D02` (INT enable), `0x1053` (accel cfg), `0x1150` (gyro cfg), `0x1460` (rounding). In each `INITn`, wait for a rising edge of `done`; then issue the next command (pulse `wrt`, load `cmd`) and advance. After the `INIT3` edge set `init_done` and go to `WAIT_INT`.
- `done` rising edge: `done & ~done_q`, with `done_q` a register reset to 0. This tolerates `done` still being high from the previous transaction on the `wrt` cycle.
- `WAIT_INT`: when synchronized INT is 1, pulse `wrt` with `cmd=0xA600` and go to `RD_L`.
- `RD_L`: on `done` edge capture `rd_data[7:0]` into low-byte holding register, pulse `wrt` with `cmd=0xA700`, go to `RD_H`.
- `RD_H`: on `done` edge load `yaw_rt <= {rd_data[7:0], low_byte}`, go to `UPDATE`.
- `UPDATE`: `vld=1` for this single cycle; go to `WAIT_INT`.
- INT is ignored in all states except `WAIT_INT`. If INT is still high on return to `WAIT_INT`, a new read pair starts immediately. INT is level-sensitive; the sensor clears it when its data is read.
- `wrt` is never asserted while a transaction is outstanding.

## Timing
- Reset values: `wrt=0`, `cmd=0x0000`, `yaw_rt=0x0000`, `vld=0`, `init_done=0`; state `PWR_WAIT`; delay counter 0; `done_q=0`.
- `wrt` and `cmd` are registered. `cmd` is updated in the same cycle `wrt` goes high and is held until the next issue.
- The first `wrt` occurs exactly 2^INIT_DLY_W clocks after `rst_n` deasserts.
- The next `wrt` follows the registered `done` edge by 1 clock.
- The `yaw_rt` update occurs 1 clock after the `RD_H` `done` edge is detected. `vld` goes high in the same cycle `yaw_rt` shows its new value.
- Reset mid-operation returns to `PWR_WAIT` with all outputs at reset values. The SPI master shares `rst_n`, so no transaction survives reset.

## Configuration
- `INT_SYNC_EN` defined: INT passes through two reset-to-0 flops before use, adding 2 clocks of INT-to-`wrt` latency.
- `INT_SYNC_EN` undefined: INT is used directly, so the read `wrt` pulses 1 clock after INT is seen high in `WAIT_INT`. This option is for benches and for a synchronous sensor model only.

## Test plan
- `INIT_DLY_W=4`, SPI master plus sensor model. Release reset → first `wrt` at clock 16 with `cmd=0x0D02`, then `0x1053`, `0x1150`, `0x1460`, one per `done` edge. `init_done` rises after the 4th edge.
- INT asserted during init → no read command issued before `init_done`. The first `0xA600` is issued after init.
- After init, raise INT; model returns low byte `0x34`, high byte `0x12` → `wrt` with `0xA600` then `0xA700`. `yaw_rt=0x1234` with a 1-cycle `vld`.
- INT held high continuously → back-to-back read pairs. `vld` pulses once per pair, and `wrt` never overlaps an outstanding transaction.
- Assert `rst_n=0` for 1 clock while in `RD_H` → next clock all outputs are at reset values and state is `PWR_WAIT`. Init sequence repeats from the first command.
- Run with and without `INT_SYNC_EN` → INT-to-`wrt` latency of 3 vs 1 clocks.

Source files
------------

// File: rtl/imu_seq_if.sv
// Command/response channel between imu_seq and the 16-bit SPI master.
// master: sequencer side (issues wrt/cmd); slave: SPI master side.
interface imu_seq_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/imu_seq.sv
// Inertial-sensor command sequencer: power-up delay, four init writes, then a yaw-rate
// read pair per data-ready interrupt. Define INT_SYNC_EN to double-flop INT before use.
module imu_seq #(
  parameter int unsigned INIT_DLY_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  imu_seq_if.master   spi,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  localparam logic [3:0] PWR_WAIT = 4'd0;
  localparam logic [3:0] INIT0    = 4'd1;
  localparam logic [3:0] INIT1    = 4'd2;
  localparam logic [3:0] INIT2    = 4'd3;
  localparam logic [3:0] INIT3    = 4'd4;
  localparam logic [3:0] WAIT_INT = 4'd5;
  localparam logic [3:0] RD_L     = 4'd6;
  localparam logic [3:0] RD_H     = 4'd7;
  localparam logic [3:0] UPDATE   = 4'd8;

  localparam logic [15:0] CMD_INT_EN = 16'h0D02;
  localparam logic [15:0] CMD_ACCEL  = 16'h1053;
  localparam logic [15:0] CMD_GYRO   = 16'h1150;
  localparam logic [15:0] CMD_ROUND  = 16'h1460;
  localparam logic [15:0] CMD_RD_L   = 16'hA600;
  localparam logic [15:0] CMD_RD_H   = 16'hA700;

  localparam logic [INIT_DLY_W-1:0] DLY_ONE = INIT_DLY_W'(1);

  logic [3:0]            state_q, state_d;
  logic [INIT_DLY_W-1:0] dly_q, dly_d;
  logic                  done_q;
  logic                  wrt_q, wrt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [15:0]           yaw_q, yaw_d;
  logic [7:0]            lo_q, lo_d;
  logic                  vld_q, vld_d;
  logic                  init_done_q, init_done_d;
  logic                  int_use;
  logic                  done_rise;
  logic                  unused_rd_hi;

`ifdef INT_SYNC_EN
  logic int_s1_q, int_s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int_s1_q <= 1'b0;
      int_s2_q <= 1'b0;
    end else begin
      int_s1_q <= INT;
      int_s2_q <= int_s1_q;
    end
  end

  assign int_use = int_s2_q;
`else
  assign int_use = INT;
`endif

  // done may still be high from the previous transaction on the wrt cycle, so act on edges only.
  assign done_rise    = spi.done & ~done_q;
  assign unused_rd_hi = ^spi.rd_data[15:8];

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    wrt_d       = 1'b0;
    cmd_d       = cmd_q;
    yaw_d       = yaw_q;
    lo_d        = lo_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      PWR_WAIT: begin
        dly_d = dly_q + DLY_ONE;
        if (&dly_q) begin
          state_d = INIT0;
          wrt_d   = 1'b1;
          cmd_d   = CMD_INT_EN;
        end
      end
      INIT0: if (done_rise) begin
        state_d = INIT1;
        wrt_d   = 1'b1;
        cmd_d   = CMD_ACCEL;
      end
      INIT1: if (done_rise) begin
        state_d = INIT2;
        wrt_d   = 1'b1;
        cmd_d   = CMD_GYRO;
      end
      INIT2: if (done_rise) begin
        state_d = INIT3;
        wrt_d   = 1'b1;
        cmd_d   = CMD_ROUND;
      end
      INIT3: if (done_rise) begin
        state_d     = WAIT_INT;
        init_done_d = 1'b1;
      end
      WAIT_INT: if (int_use) begin
        state_d = RD_L;
        wrt_d   = 1'b1;
        cmd_d   = CMD_RD_L;
      end
      RD_L: if (done_rise) begin
        state_d = RD_H;
        lo_d    = spi.rd_data[7:0];
        wrt_d   = 1'b1;
        cmd_d   = CMD_RD_H;
      end
      RD_H: if (done_rise) begin
        state_d = UPDATE;
        yaw_d   = {spi.rd_data[7:0], lo_q};
        vld_d   = 1'b1;
      end
      UPDATE:  state_d = WAIT_INT;
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      dly_q       <= '0;
      done_q      <= 1'b0;
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      yaw_q       <= 16'h0000;
      lo_q        <= 8'h00;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      done_q      <= spi.done;
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      yaw_q       <= yaw_d;
      lo_q        <= lo_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
    end
  end

  assign spi.wrt   = wrt_q;
  assign spi.cmd   = cmd_q;
  assign yaw_rt    = yaw_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_imu_seq.sv
// Bench for imu_seq: SPI master + sensor model with random latency and random sample data.
module tb_imu_seq;
  localparam int unsigned DlyW = 4;
  localparam int PwrLat = 16;
`ifdef INT_SYNC_EN
  localparam int IntLat = 3;
`else
  localparam int IntLat = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        INT;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  imu_seq_if spi ();

  imu_seq #(.INIT_DLY_W(DlyW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .spi       (spi),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] init_cmds [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  logic [15:0] samp [64];

  // Sensor interrupt: held level, or a single sample request cleared when its high byte is read.
  logic int_arm  = 1'b0;
  logic int_hold = 1'b0;
  int   arm_mark = 0;
  int   rd_idx   = 0;
  assign INT = int_hold | (int_arm & (rd_idx == arm_mark));

  // SPI master + sensor model.
  int          cyc = 0;
  logic        busy = 1'b0;
  int          lat_cnt = 0;
  logic [15:0] cur_cmd = 16'h0000;
  int          done_cyc_q [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      spi.done    <= 1'b0;
      spi.rd_data <= 16'h0000;
      busy        <= 1'b0;
    end else if (spi.wrt) begin
      spi.done <= 1'b0;
      busy     <= 1'b1;
      cur_cmd  <= spi.cmd;
      lat_cnt  <= int'($urandom_range(4, 0));
    end else if (busy) begin
      if (lat_cnt == 0) begin
        spi.done <= 1'b1;
        busy     <= 1'b0;
        done_cyc_q.push_back(cyc + 1);
        if (cur_cmd == 16'hA600) begin
          spi.rd_data <= {8'($urandom), samp[rd_idx][7:0]};
        end else if (cur_cmd == 16'hA700) begin
          spi.rd_data <= {8'($urandom), samp[rd_idx][15:8]};
          rd_idx      <= rd_idx + 1;
        end else begin
          spi.rd_data <= 16'($urandom);
        end
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // Monitor: logs issued commands and yaw updates, counts protocol violations.
  logic        rst_seen = 1'b0;
  logic        wrt_prev = 1'b0;
  logic        vld_prev = 1'b0;
  logic [15:0] yaw_prev = 16'h0000;
  logic [15:0] wrt_q [$];
  int          wrt_cyc_q [$];
  logic [15:0] yaw_q [$];
  int          vld_cyc_q [$];
  int overlap = 0, wrt_long = 0, vld_long = 0, cmd_unstable = 0, yaw_glitch = 0, early_rd = 0;

  always @(posedge clk) rst_seen <= rst_n;

  always @(negedge clk) begin
    if (spi.wrt) begin
      wrt_q.push_back(spi.cmd);
      wrt_cyc_q.push_back(cyc);
      if (busy) overlap <= overlap + 1;
      if (wrt_prev) wrt_long <= wrt_long + 1;
      if (spi.cmd == 16'hA600 && init_done !== 1'b1) early_rd <= early_rd + 1;
    end
    if (busy && spi.cmd !== cur_cmd) cmd_unstable <= cmd_unstable + 1;
    if (vld) begin
      yaw_q.push_back(yaw_rt);
      vld_cyc_q.push_back(cyc);
      if (vld_prev) vld_long <= vld_long + 1;
    end else if (rst_seen && yaw_rt !== yaw_prev) begin
      yaw_glitch <= yaw_glitch + 1;
    end
    wrt_prev <= spi.wrt;
    vld_prev <= vld;
    yaw_prev <= yaw_rt;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (spi.wrt !== 1'b0) begin n_fail++; $display("FAIL reset_wrt: got %b want 0", spi.wrt); end
    n_tests++; if (spi.cmd !== 16'h0000) begin n_fail++; $display("FAIL reset_cmd: got %h want 0000", spi.cmd); end
    n_tests++; if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL reset_yaw: got %h want 0000", yaw_rt); end
    n_tests++; if (vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", vld); end
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
  endtask

  task automatic test_init();
    int wb, db, t0;
    wb = wrt_q.size();
    db = done_cyc_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 300 && init_done !== 1'b1; i++) @(negedge clk);
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL init_timeout: init_done=%b want 1", init_done);
    end else begin
      n_tests++;
      if (wrt_q.size() - wb != 4) begin
        n_fail++; $display("FAIL init_count: got %0d cmds want 4", wrt_q.size() - wb);
      end else begin
        for (int k = 0; k < 4; k++) begin
          n_tests++;
          if (wrt_q[wb+k] !== init_cmds[k]) begin
            n_fail++; $display("FAIL init_cmd%0d: got %h want %h", k, wrt_q[wb+k], init_cmds[k]);
          end
          if (k > 0) begin
            n_tests++;
            if (wrt_cyc_q[wb+k] != done_cyc_q[db+k-1] + 1) begin
              n_fail++; $display("FAIL init_gap%0d: wrt at %0d want %0d", k, wrt_cyc_q[wb+k],
                                 done_cyc_q[db+k-1] + 1);
            end
          end
        end
        n_tests++;
        if (wrt_cyc_q[wb] - t0 != PwrLat) begin
          n_fail++; $display("FAIL pwr_delay: got %0d clocks want %0d", wrt_cyc_q[wb] - t0, PwrLat);
        end
        n_tests++;
        if (cyc != done_cyc_q[db+3] + 1) begin
          n_fail++; $display("FAIL init_done_time: got cyc %0d want %0d", cyc, done_cyc_q[db+3] + 1);
        end
      end
    end
  endtask

  task automatic test_single_read();
    int wb, yb, db, m, t0;
    wb = wrt_q.size(); yb = yaw_q.size(); db = done_cyc_q.size(); m = rd_idx;
    @(negedge clk);
    arm_mark = rd_idx;
    int_arm  = 1'b1;
    t0       = cyc;
    for (int i = 0; i < 200 && yaw_q.size() == yb; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    int_arm = 1'b0;
    n_tests++;
    if (yaw_q.size() != yb + 1 || wrt_q.size() != wb + 2) begin
      n_fail++; $display("FAIL read_count: got %0d vld %0d wrt want 1 and 2", yaw_q.size() - yb,
                         wrt_q.size() - wb);
    end else begin
      n_tests++; if (wrt_q[wb] !== 16'hA600) begin n_fail++; $display("FAIL read_cmd_lo: got %h want a600", wrt_q[wb]); end
      n_tests++; if (wrt_q[wb+1] !== 16'hA700) begin n_fail++; $display("FAIL read_cmd_hi: got %h want a700", wrt_q[wb+1]); end
      n_tests++;
      if (wrt_cyc_q[wb] - t0 != IntLat) begin
        n_fail++; $display("FAIL int_latency: got %0d clocks want %0d", wrt_cyc_q[wb] - t0, IntLat);
      end
      n_tests++;
      if (wrt_cyc_q[wb+1] != done_cyc_q[db] + 1) begin
        n_fail++; $display("FAIL read_gap: wrt at %0d want %0d", wrt_cyc_q[wb+1], done_cyc_q[db] + 1);
      end
      n_tests++; if (yaw_q[yb] !== samp[m]) begin n_fail++; $display("FAIL read_yaw: got %h want %h", yaw_q[yb], samp[m]); end
      n_tests++;
      if (vld_cyc_q[yb] != done_cyc_q[db+1] + 1) begin
        n_fail++; $display("FAIL vld_time: got cyc %0d want %0d", vld_cyc_q[yb], done_cyc_q[db+1] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int wb, yb, m, n;
    wb = wrt_q.size(); yb = yaw_q.size(); m = rd_idx;
    @(negedge clk);
    int_hold = 1'b1;
    for (int i = 0; i < 400 && yaw_q.size() < yb + 5; i++) @(negedge clk);
    int_hold = 1'b0;
    repeat (60) @(negedge clk);
    n = yaw_q.size() - yb;
    n_tests++;
    if (n < 5 || wrt_q.size() - wb != 2 * n) begin
      n_fail++; $display("FAIL b2b_count: got %0d vld %0d wrt want >=5 and 2x", n, wrt_q.size() - wb);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (yaw_q[yb+i] !== samp[m+i]) begin
          n_fail++; $display("FAIL b2b_yaw%0d: got %h want %h", i, yaw_q[yb+i], samp[m+i]);
        end
        n_tests++;
        if (wrt_q[wb+2*i] !== 16'hA600 || wrt_q[wb+2*i+1] !== 16'hA700) begin
          n_fail++; $display("FAIL b2b_cmd%0d: got %h %h want a600 a700", i, wrt_q[wb+2*i],
                             wrt_q[wb+2*i+1]);
        end
        if (i > 0 && i < 5) begin
          n_tests++;
          if (wrt_cyc_q[wb+2*i] - vld_cyc_q[yb+i-1] != 2) begin
            n_fail++; $display("FAIL b2b_restart%0d: got %0d clocks after vld want 2", i,
                               wrt_cyc_q[wb+2*i] - vld_cyc_q[yb+i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_rd();
    int wb, yb, m, t0;
    wb = wrt_q.size();
    @(negedge clk);
    arm_mark = rd_idx;
    int_arm  = 1'b1;
    for (int i = 0; i < 200 && wrt_q.size() < wb + 2; i++) @(negedge clk);
    n_tests++;
    if (wrt_q.size() < wb + 2 || wrt_q[wb+1] !== 16'hA700) begin
      n_fail++; $display("FAIL rdh_reach: got %0d cmds want a700 issued", wrt_q.size() - wb);
    end
    // One clock of reset while the high-byte read is outstanding.
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({spi.wrt, spi.cmd, yaw_rt, vld, init_done} !== 35'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got wrt=%b cmd=%h yaw=%h vld=%b init=%b want all 0",
                         spi.wrt, spi.cmd, yaw_rt, vld, init_done);
    end
    // Release with INT still requested: no read may precede init completion.
    wb = wrt_q.size(); yb = yaw_q.size(); m = rd_idx;
    arm_mark = rd_idx;
    rst_n    = 1'b1;
    t0       = cyc;
    for (int i = 0; i < 400 && yaw_q.size() == yb; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    int_arm = 1'b0;
    n_tests++;
    if (yaw_q.size() != yb + 1 || wrt_q.size() != wb + 6) begin
      n_fail++; $display("FAIL reinit_count: got %0d vld %0d wrt want 1 and 6", yaw_q.size() - yb,
                         wrt_q.size() - wb);
    end else begin
      n_tests++;
      if (wrt_cyc_q[wb] - t0 != PwrLat) begin
        n_fail++; $display("FAIL reinit_delay: got %0d clocks want %0d", wrt_cyc_q[wb] - t0, PwrLat);
      end
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (wrt_q[wb+k] !== init_cmds[k]) begin
          n_fail++; $display("FAIL reinit_cmd%0d: got %h want %h", k, wrt_q[wb+k], init_cmds[k]);
        end
      end
      n_tests++;
      if (wrt_q[wb+4] !== 16'hA600 || wrt_q[wb+5] !== 16'hA700) begin
        n_fail++; $display("FAIL reinit_read: got %h %h want a600 a700", wrt_q[wb+4], wrt_q[wb+5]);
      end
      n_tests++; if (yaw_q[yb] !== samp[m]) begin n_fail++; $display("FAIL reinit_yaw: got %h want %h", yaw_q[yb], samp[m]); end
    end
  endtask

  task automatic test_protocol();
    n_tests++; if (overlap != 0) begin n_fail++; $display("FAIL wrt_overlap: got %0d want 0", overlap); end
    n_tests++; if (wrt_long != 0) begin n_fail++; $display("FAIL wrt_width: got %0d long pulses want 0", wrt_long); end
    n_tests++; if (vld_long != 0) begin n_fail++; $display("FAIL vld_width: got %0d long pulses want 0", vld_long); end
    n_tests++; if (cmd_unstable != 0) begin n_fail++; $display("FAIL cmd_stable: got %0d changes want 0", cmd_unstable); end
    n_tests++; if (yaw_glitch != 0) begin n_fail++; $display("FAIL yaw_no_vld: got %0d changes want 0", yaw_glitch); end
    n_tests++; if (early_rd != 0) begin n_fail++; $display("FAIL early_read: got %0d want 0", early_rd); end
  endtask

  initial begin
    samp[0] = 16'h1234;
    for (int i = 1; i < 64; i++) samp[i] = 16'($urandom);
    test_reset();
    test_init();
    test_single_read();
    test_back_to_back();
    test_reset_mid_rd();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
